// File: rtl/static_fetch_if.sv
// Bundles the static_fetch control, memory read port and datapath handshake signals.
// master = fetch engine side, slave = surrounding environment (pointer reg, memory, datapath).
interface static_fetch_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] seg_base;
  logic [ADDR_W-1:0] sp_offset;
  logic              sp_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, len, seg_base, sp_offset, mem_ready, mem_rdata, out_ready,
    output sp_inc, mem_addr, mem_rd, out_data, out_valid, busy, done, err
  );

  modport slave (
    output start, len, seg_base, sp_offset, mem_ready, mem_rdata, out_ready,
    input  sp_inc, mem_addr, mem_rd, out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/static_fetch.sv
// Static-segment burst reader: reads LEN words from seg_base+sp_offset and streams them out,
// pulsing sp_inc per delivered word. Optional READ timeout abort via STATIC_FETCH_TIMEOUT_EN.
module static_fetch #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk_i,
  input  logic           reset_i,
  static_fetch_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;

`ifdef STATIC_FETCH_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
`ifdef STATIC_FETCH_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.seg_base + bus.sp_offset;
          rem_d   = bus.len;
          state_d = (bus.len == '0) ? ST_DONE : ST_READ;
`ifdef STATIC_FETCH_TIMEOUT_EN
          wait_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_READ: begin
        if (bus.mem_ready) begin
          data_d  = bus.mem_rdata;
          state_d = ST_HOLD;
        end
`ifdef STATIC_FETCH_TIMEOUT_EN
        // The last tolerated stall cycle aborts the whole burst; remaining words are dropped.
        else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_READ;
`ifdef STATIC_FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
`ifdef STATIC_FETCH_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
`ifdef STATIC_FETCH_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.mem_rd    = (state_q == ST_READ);
  assign bus.mem_addr  = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == ST_HOLD);
  // Gated by reset so a reset arriving during HOLD cannot advance the pointer register.
  assign bus.sp_inc    = (state_q == ST_HOLD) && bus.out_ready && reset_i;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

`ifdef STATIC_FETCH_TIMEOUT_EN
  assign bus.err = (state_q == ST_DONE) && err_q;
`else
  // Without the timeout build err is constant low for any legal TIMEOUT_CYCLES.
  assign bus.err = (TIMEOUT_CYCLES < 0);
`endif

endmodule
